hamming_secded_decoder: RTL and testbench
=========================================

Name: hamming_secded_decoder

Overview:
Parametrised, pipelined SECDED (single-error-correct, double-error-detect) Hamming decoder. It is the receive-side companion to the team's systematic Hamming encoder, generalised from the fixed (7,4) code to any data width plus an overall parity bit. It sits on the receive datapath between the demodulator/deframer and the data sink, uses valid/ready handshakes on both sides, and keeps saturating error statistics.

Parameters:
- DATA_W, 4: data bits per codeword. Legal range 4..57.
- PAR_W, derived (localparam): smallest P with 2^P >= DATA_W+P+1. PAR_W is 3 for DATA_W=4.
- CW_W, derived (localparam): DATA_W+PAR_W+1, the codeword width.
- CORRECT_EN, 1: 1 means single errors are corrected; 0 means detect-only, and out_data is the raw received data.
- CNT_W, 16: width of each error counter.

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  in_code is valid.
- in_ready  out  1  the decoder accepts in_code this cycle.
- in_code  in  CW_W  received codeword.
- out_valid  out  1  output word is valid.
- out_ready  in  1  the sink accepts the output word.
- out_data  out  DATA_W  decoded data.
- out_err_corr  out  1  single error detected (and corrected when CORRECT_EN=1).
- out_err_uncorr  out  1  double error detected; out_data is raw and unreliable.
- out_syndrome  out  PAR_W  Hamming syndrome of this word.
- cnt_clr  in  1  synchronous clear of both counters.
- corr_cnt  out  CNT_W  count of words with a single error.
- uncorr_cnt  out  CNT_W  count of words with an uncorrectable error.

Behaviour:
- Codeword layout (systematic):
  - in_code[CW_W-1] = overall parity bit (even parity over the whole codeword).
  - in_code[CW_W-2:PAR_W] = data d[DATA_W-1:0].
  - in_code[PAR_W-1:0] = check bits c[PAR_W-1:0].
- Hamming position of data bit j = the j-th integer >=3 that is not a power of two. For DATA_W=4 these are 3, 5, 6, 7.
- c[i] = XOR of all data bits whose position has bit i set. Check bit i has position 2^i.
- Syndrome S = recomputed check bits XOR received check bits. Parity error pe = XOR of all CW_W received bits.
- Classification:
  - S=0, pe=0: clean.
  - pe=1: single error, so corr=1. If S is a data-bit position, that data bit is flipped (when CORRECT_EN=1). If S is a power of two or 0, the error is in a check or parity bit and the data passes unchanged.
  - S!=0, pe=0: uncorr=1 and the data passes raw.
  - The corr and uncorr flags are never both 1.
- Pipeline: two register stages, S1 and S2.
  - S1 registers the data, syndrome and pe.
  - S2 registers the corrected data and the flags, which drive the out_* ports.
  - Latency is 2 cycles from the accept edge to out_valid when there is no backpressure.
  - Throughput is 1 word per cycle.
- Handshake:
  - adv2 = !s2_valid || out_ready. adv1 = adv2 (S1 moves into S2).
  - in_ready = !s1_valid || adv1 (combinational).
  - A transfer occurs on valid && ready.
  - While out_valid=1 and out_ready=0, all out_* ports hold stable.
  - in_code is not required to stay stable after it is accepted.
- Counters:
  - Update when an out transfer occurs: corr_cnt increments if out_err_corr=1; uncorr_cnt increments if out_err_uncorr=1.
  - Both counters saturate at 2^CNT_W-1 with no wrap.
  - cnt_clr=1 zeroes both counters; a coincident increment is dropped (clear wins).
  - Counters are unaffected by CORRECT_EN.
- Reset (asynchronous, rst_n low):
  - s1_valid, out_valid, out_data, the flags, out_syndrome, corr_cnt and uncorr_cnt all go to 0.
  - in_ready reads 1 once rst_n is high.
  - Words in flight are discarded with no partial output.
- Simultaneous events: with both stages full and out_ready=1, a new word is accepted in the same cycle the S2 word leaves, with no bubble.

Test Plan:
- DATA_W=4, in_code=8'h59 (data 1011, c=001, op=0) -> 2 cycles later out_data=4'hB, corr=0, uncorr=0, syndrome=0.
- in_code=8'h79 (data bit d2 flipped) -> out_data=4'hB, corr=1, syndrome=3'b110, corr_cnt=1. With CORRECT_EN=0: out_data=4'hF, corr=1.
- in_code=8'h78 (bits 0 and 5 flipped) -> uncorr=1, corr=0, out_data=4'hF, uncorr_cnt=1. Also in_code=8'hD9 (only the parity bit flipped) -> out_data=4'hB, corr=1, syndrome=0.
- Stream 6 back-to-back words while out_ready is held low for cycles 3-5 -> in_ready drops after 2 buffered words, outputs stay stable, all 6 words emerge in order with none lost or duplicated.
- CNT_W=2: 5 single-error words -> corr_cnt saturates at 3. Then cnt_clr pulsed in the same cycle as a corrected-word transfer -> corr_cnt=0.
- Assert rst_n low while both stages are full -> out_valid=0 immediately (asynchronously) and both counters read 0. After release, the first new word appears 2 cycles after it is accepted.

Source files
------------

// File: rtl/hamming_secded_decoder.sv
// Purpose : pipelined SECDED Hamming decoder (systematic layout) with saturating error statistics.
// Latency : 2 cycles accept-to-output (S1 syndrome, S2 correction), 1 word/cycle throughput.
// Backpr. : valid/ready both sides; in_ready = !s1_valid || adv, outputs frozen while stalled.
//
// Ports:
//   clk, rst_n                 clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready/in_code  receive side, codeword = {overall parity, data, check bits}
//   out_valid/out_ready        sink side handshake
//   out_data                   decoded (or raw) data
//   out_err_corr               single error seen (data corrected when CORRECT_EN=1)
//   out_err_uncorr             double error seen, out_data is raw
//   out_syndrome               Hamming syndrome of the word
//   cnt_clr                    synchronous clear of both counters (beats a coincident increment)
//   corr_cnt/uncorr_cnt        saturating per-class word counters, stepped on output transfers
module hamming_secded_decoder #(
   parameter int DATA_W     = 4,
   parameter bit CORRECT_EN = 1'b1,
   parameter int CNT_W      = 16,
   // Smallest P with 2^P >= DATA_W+P+1, tabulated over the legal 4..57 range.
   localparam int PAR_W     = (DATA_W <= 4)  ? 3 :
                              (DATA_W <= 11) ? 4 :
                              (DATA_W <= 26) ? 5 : 6,
   localparam int CW_W      = DATA_W + PAR_W + 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [CW_W-1:0]   in_code,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              out_err_corr,
   output logic              out_err_uncorr,
   output logic [PAR_W-1:0]  out_syndrome,
   input  logic              cnt_clr,
   output logic [CNT_W-1:0]  corr_cnt,
   output logic [CNT_W-1:0]  uncorr_cnt
);

   // Hamming position of data bit j: the j-th integer >= 3 that is not a power of two.
   // Positions never exceed 63 for the legal DATA_W range.
   function automatic int data_pos(input int j);
      int n;
      int r;
      n = 0;
      r = 0;
      for (int p = 3; p < 64; p++) begin
         if ((p & (p - 1)) != 0) begin
            if (n == j) r = p;
            n++;
         end
      end
      return r;
   endfunction

   // Data bits covered by check bit i: those whose position has bit i set.
   function automatic logic [DATA_W-1:0] check_mask(input int i);
      logic [DATA_W-1:0] m;
      m = '0;
      for (int j = 0; j < DATA_W; j++) begin
         m[j] = ((data_pos(j) >> i) & 1) != 0;
      end
      return m;
   endfunction

   // ---------------------------------------------------------------- handshake
   logic s1_vld_q, s1_vld_d;
   logic s2_vld_q, s2_vld_d;
   logic adv2;
   logic adv1;
   logic out_xfer;

   assign adv2     = !s2_vld_q || out_ready;
   assign adv1     = adv2;
   assign in_ready = !s1_vld_q || adv1;
   assign out_xfer = s2_vld_q && out_ready;

   // ---------------------------------------------------------------- stage 0 (comb)
   logic [DATA_W-1:0] rx_data;
   logic [PAR_W-1:0]  rx_chk;
   logic [PAR_W-1:0]  syn_calc;
   logic              pe_calc;

   assign rx_data = in_code[CW_W-2:PAR_W];
   assign rx_chk  = in_code[PAR_W-1:0];
   assign pe_calc = ^in_code;

   for (genvar gi = 0; gi < PAR_W; gi++) begin : g_syn
      localparam logic [DATA_W-1:0] MASK = check_mask(gi);
      assign syn_calc[gi] = (^(rx_data & MASK)) ^ rx_chk[gi];
   end

   // ---------------------------------------------------------------- stage 1 regs
   logic [DATA_W-1:0] s1_data_q, s1_data_d;
   logic [PAR_W-1:0]  s1_syn_q,  s1_syn_d;
   logic              s1_pe_q,   s1_pe_d;

   always_comb begin
      s1_vld_d  = s1_vld_q;
      s1_data_d = s1_data_q;
      s1_syn_d  = s1_syn_q;
      s1_pe_d   = s1_pe_q;
      if (in_ready) begin
         s1_vld_d = in_valid;
         if (in_valid) begin
            s1_data_d = rx_data;
            s1_syn_d  = syn_calc;
            s1_pe_d   = pe_calc;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_vld_q  <= 1'b0;
         s1_data_q <= '0;
         s1_syn_q  <= '0;
         s1_pe_q   <= 1'b0;
      end else begin
         s1_vld_q  <= s1_vld_d;
         s1_data_q <= s1_data_d;
         s1_syn_q  <= s1_syn_d;
         s1_pe_q   <= s1_pe_d;
      end
   end

   // ---------------------------------------------------------------- correction (comb)
   // A data bit flips only for an odd-weight error whose syndrome names its position;
   // syndromes of 0 or a power of two point at the parity/check bits, so data is untouched.
   logic [DATA_W-1:0] flip;
   logic [DATA_W-1:0] fixed_data;
   logic              corr_flag;
   logic              uncorr_flag;

   for (genvar gj = 0; gj < DATA_W; gj++) begin : g_flip
      localparam int POS = data_pos(gj);
      assign flip[gj] = s1_pe_q && (s1_syn_q == PAR_W'(POS));
   end

   assign fixed_data  = CORRECT_EN ? (s1_data_q ^ flip) : s1_data_q;
   assign corr_flag   = s1_pe_q;
   assign uncorr_flag = !s1_pe_q && (|s1_syn_q);

   // ---------------------------------------------------------------- stage 2 regs
   logic [DATA_W-1:0] s2_data_q,   s2_data_d;
   logic              s2_corr_q,   s2_corr_d;
   logic              s2_uncorr_q, s2_uncorr_d;
   logic [PAR_W-1:0]  s2_syn_q,    s2_syn_d;

   always_comb begin
      s2_vld_d    = s2_vld_q;
      s2_data_d   = s2_data_q;
      s2_corr_d   = s2_corr_q;
      s2_uncorr_d = s2_uncorr_q;
      s2_syn_d    = s2_syn_q;
      if (adv2) begin
         s2_vld_d = s1_vld_q;
         if (s1_vld_q) begin
            s2_data_d   = fixed_data;
            s2_corr_d   = corr_flag;
            s2_uncorr_d = uncorr_flag;
            s2_syn_d    = s1_syn_q;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s2_vld_q    <= 1'b0;
         s2_data_q   <= '0;
         s2_corr_q   <= 1'b0;
         s2_uncorr_q <= 1'b0;
         s2_syn_q    <= '0;
      end else begin
         s2_vld_q    <= s2_vld_d;
         s2_data_q   <= s2_data_d;
         s2_corr_q   <= s2_corr_d;
         s2_uncorr_q <= s2_uncorr_d;
         s2_syn_q    <= s2_syn_d;
      end
   end

   assign out_valid      = s2_vld_q;
   assign out_data       = s2_data_q;
   assign out_err_corr   = s2_corr_q;
   assign out_err_uncorr = s2_uncorr_q;
   assign out_syndrome   = s2_syn_q;

   // ---------------------------------------------------------------- statistics
   logic [CNT_W-1:0] corr_cnt_q,   corr_cnt_d;
   logic [CNT_W-1:0] uncorr_cnt_q, uncorr_cnt_d;

   always_comb begin
      corr_cnt_d   = corr_cnt_q;
      uncorr_cnt_d = uncorr_cnt_q;
      if (cnt_clr) begin
         corr_cnt_d   = '0;
         uncorr_cnt_d = '0;
      end else if (out_xfer) begin
         if (s2_corr_q && (corr_cnt_q != {CNT_W{1'b1}})) begin
            corr_cnt_d = corr_cnt_q + CNT_W'(1);
         end
         if (s2_uncorr_q && (uncorr_cnt_q != {CNT_W{1'b1}})) begin
            uncorr_cnt_d = uncorr_cnt_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         corr_cnt_q   <= '0;
         uncorr_cnt_q <= '0;
      end else begin
         corr_cnt_q   <= corr_cnt_d;
         uncorr_cnt_q <= uncorr_cnt_d;
      end
   end

   assign corr_cnt   = corr_cnt_q;
   assign uncorr_cnt = uncorr_cnt_q;

endmodule

// File: tb/tb_hamming_secded_decoder.sv
// Bench for hamming_secded_decoder: three instances share the handshake/control inputs.
//   A: DATA_W=4,  correcting,  16-bit counters
//   B: DATA_W=4,  detect-only, 2-bit counters (saturation)
//   C: DATA_W=11, correcting,  16-bit counters (wider code)
module tb_hamming_secded_decoder;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n, in_valid, out_ready, cnt_clr;
   logic [7:0]  code_ab;
   logic [15:0] code_c;

   logic        in_ready_a, out_valid_a, corr_a, uncorr_a;
   logic [3:0]  data_a;
   logic [2:0]  syn_a;
   logic [15:0] ccnt_a, ucnt_a;

   logic        in_ready_b, out_valid_b, corr_b, uncorr_b;
   logic [3:0]  data_b;
   logic [2:0]  syn_b;
   logic [1:0]  ccnt_b, ucnt_b;

   logic        in_ready_c, out_valid_c, corr_c, uncorr_c;
   logic [10:0] data_c;
   logic [3:0]  syn_c;
   logic [15:0] ccnt_c, ucnt_c;

   hamming_secded_decoder #(.DATA_W(4), .CORRECT_EN(1'b1), .CNT_W(16)) u_a (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_a), .in_code(code_ab),
      .out_valid(out_valid_a), .out_ready(out_ready), .out_data(data_a),
      .out_err_corr(corr_a), .out_err_uncorr(uncorr_a), .out_syndrome(syn_a),
      .cnt_clr(cnt_clr), .corr_cnt(ccnt_a), .uncorr_cnt(ucnt_a));

   hamming_secded_decoder #(.DATA_W(4), .CORRECT_EN(1'b0), .CNT_W(2)) u_b (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_b), .in_code(code_ab),
      .out_valid(out_valid_b), .out_ready(out_ready), .out_data(data_b),
      .out_err_corr(corr_b), .out_err_uncorr(uncorr_b), .out_syndrome(syn_b),
      .cnt_clr(cnt_clr), .corr_cnt(ccnt_b), .uncorr_cnt(ucnt_b));

   hamming_secded_decoder #(.DATA_W(11), .CORRECT_EN(1'b1), .CNT_W(16)) u_c (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_c), .in_code(code_c),
      .out_valid(out_valid_c), .out_ready(out_ready), .out_data(data_c),
      .out_err_corr(corr_c), .out_err_uncorr(uncorr_c), .out_syndrome(syn_c),
      .cnt_clr(cnt_clr), .corr_cnt(ccnt_c), .uncorr_cnt(ucnt_c));

   int ncomp = 0;
   int nfail = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      ncomp++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // ---------------------------------------------------------------- reference model
   // Classic positional Hamming view: syndrome = XOR of the positions of all set bits.
   function automatic int pos_of(input int j);
      int n = 0;
      int r = 0;
      for (int p = 3; p < 128; p++) begin
         if ((p & (p - 1)) != 0) begin
            if (n == j) r = p;
            n++;
         end
      end
      return r;
   endfunction

   function automatic logic [63:0] encode(input logic [63:0] d, input int dw, input int pw);
      int s = 0;
      logic [63:0] cw;
      for (int j = 0; j < dw; j++) if (d[j]) s = s ^ pos_of(j);
      cw = ((d & ((64'd1 << dw) - 64'd1)) << pw) | 64'(s);
      cw[dw + pw] = ^cw;
      return cw;
   endfunction

   typedef struct {
      logic [63:0] d;
      logic        c;
      logic        u;
      int          s;
   } dec_t;

   function automatic dec_t decode(input logic [63:0] cw, input int dw, input int pw, input bit ce);
      dec_t r;
      logic pe = 1'b0;
      int   s  = 0;
      for (int b = 0; b < dw + pw + 1; b++) pe = pe ^ cw[b];
      for (int j = 0; j < dw; j++) if (cw[pw + j]) s = s ^ pos_of(j);
      for (int i = 0; i < pw; i++) if (cw[i]) s = s ^ (1 << i);
      r.d = (cw >> pw) & ((64'd1 << dw) - 64'd1);
      r.c = pe;
      r.u = !pe && (s != 0);
      r.s = s;
      if (pe && ce) begin
         for (int j = 0; j < dw; j++) if (pos_of(j) == s) r.d[j] = ~r.d[j];
      end
      return r;
   endfunction

   typedef struct {
      dec_t a;
      dec_t b;
      dec_t c;
   } exp_t;

   exp_t exp_q[$];
   int   mca, mua, mcb, mub, mcc, muc;
   int   nout;
   bit   last_in_x;
   bit   stall_prev;
   logic [27:0] held;

   function automatic int sat_inc(input int v, input int maxv);
      return (v < maxv) ? v + 1 : v;
   endfunction

   // One clock: sample handshake just before the edge, score it, then advance to the next negedge.
   task automatic tick();
      exp_t e;
      bit in_x, out_x;
      logic [27:0] now;
      #1;
      in_x  = in_valid && in_ready_a;
      out_x = out_valid_a && out_ready;
      now   = {out_valid_a, data_a, corr_a, uncorr_a, syn_a,
               out_valid_c, data_c, corr_c, uncorr_c, syn_c};
      if (stall_prev) check("hold", now, held);
      stall_prev = out_valid_a && !out_ready;
      held       = now;
      if (out_x) begin
         nout++;
         check("vld_bc", {out_valid_b, out_valid_c}, 2'b11);
         if (exp_q.size() == 0) begin
            check("spurious_out", 1'b1, 1'b0);
         end else begin
            e = exp_q.pop_front();
            check("out_a", {data_a, corr_a, uncorr_a, syn_a},
                  {e.a.d[3:0], e.a.c, e.a.u, 3'(e.a.s)});
            check("out_b", {data_b, corr_b, uncorr_b, syn_b},
                  {e.b.d[3:0], e.b.c, e.b.u, 3'(e.b.s)});
            check("out_c", {data_c, corr_c, uncorr_c, syn_c},
                  {e.c.d[10:0], e.c.c, e.c.u, 4'(e.c.s)});
            if (!cnt_clr) begin
               if (e.a.c) begin mca = sat_inc(mca, 65535); mcb = sat_inc(mcb, 3); end
               if (e.a.u) begin mua = sat_inc(mua, 65535); mub = sat_inc(mub, 3); end
               if (e.c.c) mcc = sat_inc(mcc, 65535);
               if (e.c.u) muc = sat_inc(muc, 65535);
            end
         end
      end
      if (cnt_clr) begin
         mca = 0; mua = 0; mcb = 0; mub = 0; mcc = 0; muc = 0;
      end
      if (in_x) begin
         e.a = decode(64'(code_ab), 4, 3, 1'b1);
         e.b = decode(64'(code_ab), 4, 3, 1'b0);
         e.c = decode(64'(code_c), 11, 4, 1'b1);
         exp_q.push_back(e);
      end
      last_in_x = in_x;
      @(posedge clk);
      @(negedge clk);
      check("cnt_a", {ccnt_a, ucnt_a}, {16'(mca), 16'(mua)});
      check("cnt_b", {ccnt_b, ucnt_b}, {2'(mcb), 2'(mub)});
      check("cnt_c", {ccnt_c, ucnt_c}, {16'(mcc), 16'(muc)});
   endtask

   // Random codeword for each width with up to nerr_max flipped bits.
   task automatic gen(output logic [7:0] ab, output logic [15:0] c, input int nerr_max);
      logic [63:0] cw;
      int k, b1, b2;
      cw = encode(64'($urandom), 4, 3);
      ab = cw[7:0];
      k  = $urandom_range(0, nerr_max);
      b1 = $urandom_range(0, 7);
      b2 = (b1 + $urandom_range(1, 7)) % 8;
      if (k >= 1) ab[b1] = ~ab[b1];
      if (k == 2) ab[b2] = ~ab[b2];
      cw = encode(64'($urandom), 11, 4);
      c  = cw[15:0];
      k  = $urandom_range(0, nerr_max);
      b1 = $urandom_range(0, 15);
      b2 = (b1 + $urandom_range(1, 15)) % 16;
      if (k >= 1) c[b1] = ~c[b1];
      if (k == 2) c[b2] = ~c[b2];
   endtask

   // Send one word into an empty pipe and stop with its result on the outputs.
   task automatic send_wait(input logic [7:0] ab);
      logic [7:0]  dummy;
      logic [15:0] cc;
      gen(dummy, cc, 2);
      code_ab   = ab;
      code_c    = cc;
      in_valid  = 1'b1;
      out_ready = 1'b1;
      tick();
      in_valid = 1'b0;
      code_ab  = 8'($urandom);
      code_c   = 16'($urandom);
      check("lat1", out_valid_a, 1'b0);
      tick();
      check("lat2", out_valid_a, 1'b1);
   endtask

   logic [7:0]  wa [6];
   logic [15:0] wc [6];
   int sent, nout0;

   initial begin
      rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1; cnt_clr = 1'b0;
      code_ab = '0; code_c = '0;
      mca = 0; mua = 0; mcb = 0; mub = 0; mcc = 0; muc = 0;
      nout = 0; stall_prev = 1'b0; held = '0; last_in_x = 1'b0;

      // Reset state
      #2 rst_n = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_out_a", {out_valid_a, data_a, corr_a, uncorr_a, syn_a}, '0);
      check("rst_cnt", {ccnt_a, ucnt_a, ccnt_b, ucnt_b, ccnt_c, ucnt_c}, '0);
      rst_n = 1'b1;
      #1 check("rst_in_ready", in_ready_a, 1'b1);

      // Directed codewords (DATA_W=4)
      send_wait(8'h59);
      check("w59", {data_a, corr_a, uncorr_a, syn_a}, {4'hB, 1'b0, 1'b0, 3'b000});
      tick();
      send_wait(8'h79);
      check("w79_a", {data_a, corr_a, uncorr_a, syn_a}, {4'hB, 1'b1, 1'b0, 3'b110});
      check("w79_b", {data_b, corr_b}, {4'hF, 1'b1});
      tick();
      check("w79_cnt", ccnt_a, 16'd1);
      send_wait(8'h78);
      check("w78_a", {data_a, corr_a, uncorr_a}, {4'hF, 1'b0, 1'b1});
      tick();
      check("w78_cnt", ucnt_a, 16'd1);
      send_wait(8'hD9);
      check("wD9_a", {data_a, corr_a, uncorr_a, syn_a}, {4'hB, 1'b1, 1'b0, 3'b000});
      tick();

      // 2-bit counter saturation
      for (int i = 0; i < 5; i++) begin
         send_wait(8'h79);
         tick();
      end
      check("sat_b", ccnt_b, 2'd3);

      // Clear coincident with a corrected-word transfer
      send_wait(8'h79);
      cnt_clr = 1'b1;
      tick();
      cnt_clr = 1'b0;
      check("clr_win", {ccnt_a, ccnt_b}, '0);

      // Back-to-back stream with the sink stalled for cycles 3..5
      for (int i = 0; i < 6; i++) gen(wa[i], wc[i], 1);
      sent  = 0;
      nout0 = nout;
      for (int cyc = 0; cyc < 16; cyc++) begin
         out_ready = !(cyc >= 3 && cyc <= 5);
         in_valid  = (sent < 6);
         if (sent < 6) begin
            code_ab = wa[sent];
            code_c  = wc[sent];
         end
         if (cyc == 4) begin
            #1 check("bp_in_ready", in_ready_a, 1'b0);
         end
         tick();
         if (last_in_x) sent++;
      end
      in_valid = 1'b0;
      check("bp_count", {8'(sent), 8'(nout - nout0), 8'(exp_q.size())}, {8'd6, 8'd6, 8'd0});

      // Random traffic
      for (int cyc = 0; cyc < 400; cyc++) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 3) != 0);
         cnt_clr   = ($urandom_range(0, 40) == 0);
         gen(code_ab, code_c, 2);
         tick();
      end
      in_valid = 1'b0; cnt_clr = 1'b0; out_ready = 1'b1;
      for (int cyc = 0; cyc < 6; cyc++) tick();
      check("drain", exp_q.size(), 0);

      // Asynchronous reset with both stages full
      out_ready = 1'b0;
      in_valid  = 1'b1;
      gen(code_ab, code_c, 1);
      tick();
      gen(code_ab, code_c, 1);
      tick();
      in_valid = 1'b0;
      check("full_pre_rst", {out_valid_a, in_ready_a}, 2'b10);
      #2 rst_n = 1'b0;
      #1;
      check("arst_out", {out_valid_a, out_valid_b, out_valid_c}, 3'b000);
      check("arst_cnt", {ccnt_a, ucnt_a, ccnt_b, ucnt_b, ccnt_c, ucnt_c}, '0);
      exp_q.delete();
      mca = 0; mua = 0; mcb = 0; mub = 0; mcc = 0; muc = 0;
      stall_prev = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      #1 check("arst_in_ready", in_ready_a, 1'b1);
      send_wait(8'h59);
      check("post_rst", {data_a, corr_a, uncorr_a}, {4'hB, 1'b0, 1'b0});
      tick();
      tick();
      check("post_rst_drain", {out_valid_a, 8'(exp_q.size())}, '0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nfail);
      $finish;
   end

endmodule
